// File: rtl/udp_framer_pkg.sv
// Shared types, constants and checksum helper for the AXI-stream Ethernet/IPv4/UDP framer.
package udp_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    HEADER,
    PAYLOAD,
    PAD,
    DRAIN
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam int unsigned HDR_BYTES      = 42;
  localparam int unsigned MIN_FRAME      = 60;

  // Byte offsets of header fields within the emitted frame
  localparam int unsigned OFF_DST_MAC   = 0;
  localparam int unsigned OFF_SRC_MAC   = 6;
  localparam int unsigned OFF_ETHERTYPE = 12;
  localparam int unsigned OFF_IP_VER    = 14;
  localparam int unsigned OFF_IP_LEN    = 16;
  localparam int unsigned OFF_IP_ID     = 18;
  localparam int unsigned OFF_IP_FLAGS  = 20;
  localparam int unsigned OFF_IP_TTL    = 22;
  localparam int unsigned OFF_IP_PROTO  = 23;
  localparam int unsigned OFF_IP_CSUM   = 24;
  localparam int unsigned OFF_SRC_IP    = 26;
  localparam int unsigned OFF_DST_IP    = 30;
  localparam int unsigned OFF_SRC_PORT  = 34;
  localparam int unsigned OFF_DST_PORT  = 36;
  localparam int unsigned OFF_UDP_LEN   = 38;
  localparam int unsigned OFF_UDP_CSUM  = 40;

  // Two end-around-carry folds bring a 20-bit one's-complement sum to 16 bits.
  function automatic logic [15:0] csum_fold(input logic [19:0] acc);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
    return s2[15:0];
  endfunction

endpackage

// File: rtl/ipv4_hdr_csum.sv
// Two-stage IPv4 header checksum: stage 1 accumulates the fixed fields plus ip_len,
// stage 2 (combinational on the registered sum) folds and inverts; done marks stage 2.
module ipv4_hdr_csum
  import udp_framer_pkg::*;
#(
  parameter logic [7:0]  TTL    = 8'd64,
  parameter logic [31:0] SRC_IP = 32'hC0A8_010A,
  parameter logic [31:0] DST_IP = 32'hC0A8_0164
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] ip_len,
  output logic        done,
  output logic [15:0] csum
);

  logic [19:0] acc_q;
  logic [19:0] sum;
  logic        s1_q;

  always_comb begin
    sum = 20'h04500
        + {4'd0, ip_len}
        + 20'h00000
        + 20'h04000
        + {4'd0, TTL, IP_PROTO_UDP}
        + {4'd0, SRC_IP[31:16]}
        + {4'd0, SRC_IP[15:0]}
        + {4'd0, DST_IP[31:16]}
        + {4'd0, DST_IP[15:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      s1_q  <= 1'b0;
    end else begin
      s1_q <= start;
      if (start) acc_q <= sum;
    end
  end

  assign done = s1_q;
  assign csum = ~csum_fold(acc_q);

endmodule

// File: rtl/axis_udp_framer.sv
// Wraps a byte-wide payload packet into an Ethernet II / IPv4 / UDP frame.
// Optional minimum-frame zero padding is built when UDP_FRAMER_PAD_EN is defined.
module axis_udp_framer
  import udp_framer_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_010A,
  parameter logic [31:0] DST_IP      = 32'hC0A8_0164,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd5001,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_axis_data,
  input  logic        s_axis_valid,
  input  logic        s_axis_last,
  input  logic [11:0] s_axis_tuser,
  output logic        s_axis_ready,
  output logic [7:0]  m_axis_data,
  output logic        m_axis_valid,
  output logic        m_axis_last,
  input  logic        m_axis_ready,
  output logic        err_len
);

  localparam logic [11:0] MAX_L    = 12'(MAX_PAYLOAD);
  localparam logic [5:0]  HDR_LAST = 6'(HDR_BYTES - 1);
`ifdef UDP_FRAMER_PAD_EN
  localparam logic [11:0] PAD_TARGET = 12'(MIN_FRAME - HDR_BYTES);
`endif

  state_t state_q, state_d;

  logic [11:0]  len_q;
  logic [5:0]   hdr_cnt_q;
  logic [11:0]  pay_cnt_q;
  logic [335:0] hdr_q;
  logic [11:0]  pay_next;
  logic [15:0]  ip_len;
  logic [15:0]  udp_len;
  logic [15:0]  hdr_csum;
  logic         csum_start;
  logic         csum_done;
  logic         len_load;
  logic         hdr_load;
  logic         hdr_shift;
  logic         pay_inc;
  logic         err_set;
  logic         end_pkt;
  logic         pad_need;

  assign ip_len   = 16'(len_q) + 16'd28;
  assign udp_len  = 16'(len_q) + 16'd8;
  assign pay_next = pay_cnt_q + 12'd1;

  ipv4_hdr_csum #(
    .TTL    (TTL),
    .SRC_IP (SRC_IP),
    .DST_IP (DST_IP)
  ) u_csum (
    .clk    (clk),
    .reset  (reset),
    .start  (csum_start),
    .ip_len (ip_len),
    .done   (csum_done),
    .csum   (hdr_csum)
  );

  always_comb begin
`ifdef UDP_FRAMER_PAD_EN
    pad_need = (pay_next < PAD_TARGET);
`else
    pad_need = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    s_axis_ready = 1'b0;
    m_axis_data  = 8'h00;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    csum_start   = 1'b0;
    len_load     = 1'b0;
    hdr_load     = 1'b0;
    hdr_shift    = 1'b0;
    pay_inc      = 1'b0;
    err_set      = 1'b0;
    end_pkt      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axis_valid) begin
          len_load = 1'b1;
          if (s_axis_tuser > MAX_L) begin
            err_set = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        csum_start = ~csum_done;
        if (csum_done) begin
          hdr_load = 1'b1;
          state_d  = HEADER;
        end
      end
      HEADER: begin
        m_axis_valid = 1'b1;
        m_axis_data  = hdr_q[335:328];
`ifndef UDP_FRAMER_PAD_EN
        m_axis_last  = (hdr_cnt_q == HDR_LAST) && (len_q == '0);
`endif
        if (m_axis_ready) begin
          hdr_shift = 1'b1;
          if (hdr_cnt_q == HDR_LAST) begin
            if (len_q != '0)
              state_d = PAYLOAD;
            else begin
`ifdef UDP_FRAMER_PAD_EN
              state_d = PAD;
`else
              state_d = IDLE;
`endif
            end
          end
        end
      end
      PAYLOAD: begin
        m_axis_data  = s_axis_data;
        m_axis_valid = s_axis_valid;
        s_axis_ready = m_axis_ready;
        end_pkt      = s_axis_last || (pay_next == len_q);
        // A length overrun goes straight to DRAIN, so it must close the frame itself.
        m_axis_last  = s_axis_valid && end_pkt && (!s_axis_last || !pad_need);
        if (s_axis_valid && m_axis_ready) begin
          pay_inc = 1'b1;
          if (end_pkt) begin
            if (!s_axis_last) begin
              err_set = 1'b1;
              state_d = DRAIN;
            end else begin
              err_set = (pay_next != len_q);
              state_d = pad_need ? PAD : IDLE;
            end
          end
        end
      end
`ifdef UDP_FRAMER_PAD_EN
      PAD: begin
        m_axis_valid = 1'b1;
        m_axis_last  = (pay_cnt_q == PAD_TARGET - 12'd1);
        if (m_axis_ready) begin
          pay_inc = 1'b1;
          if (m_axis_last) state_d = IDLE;
        end
      end
`endif
      DRAIN: begin
        s_axis_ready = 1'b1;
        if (s_axis_valid && s_axis_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      hdr_q     <= '0;
      err_len   <= 1'b0;
    end else begin
      err_len <= err_set;
      if (len_load) len_q <= s_axis_tuser;
      if (hdr_load) begin
        hdr_cnt_q <= '0;
        pay_cnt_q <= '0;
        hdr_q     <= {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, 8'h45, 8'h00, ip_len,
                      16'h0000, 16'h4000, TTL, IP_PROTO_UDP, hdr_csum,
                      SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len, 16'h0000};
      end else begin
        if (hdr_shift) begin
          hdr_q     <= {hdr_q[327:0], 8'h00};
          hdr_cnt_q <= hdr_cnt_q + 6'd1;
        end
        if (pay_inc) pay_cnt_q <= pay_next;
      end
    end
  end

endmodule

// File: tb/tb_axis_udp_framer.sv
// Directed self-checking bench for axis_udp_framer; expectations follow UDP_FRAMER_PAD_EN.
module tb_axis_udp_framer;
  import udp_framer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_axis_data;
  logic        s_axis_valid;
  logic        s_axis_last;
  logic [11:0] s_axis_tuser;
  logic        s_axis_ready;
  logic [7:0]  m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_last;
  logic        m_axis_ready;
  logic        err_len;

  int checks = 0;
  int failures = 0;

  logic [7:0] pay_mem [0:1999];
  logic [7:0] cap_q [$];
  logic [7:0] exp_q [$];
  int last_idx, last_cnt, err_cnt, hs_count;
  bit valid_seen;
  bit toggle_ready = 1'b0;

  axis_udp_framer dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .err_len      (err_len)
  );

  initial forever #5 clk = ~clk;

  initial begin
    m_axis_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_axis_ready = toggle_ready ? ~m_axis_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_axis_valid && m_axis_ready) begin
      cap_q.push_back(m_axis_data);
      if (m_axis_last) begin
        last_idx = cap_q.size() - 1;
        last_cnt++;
      end
    end
    if (err_len) err_cnt++;
    if (m_axis_valid) valid_seen = 1'b1;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic clear_mon();
    cap_q.delete();
    last_idx = -1;
    last_cnt = 0;
    err_cnt = 0;
    valid_seen = 1'b0;
  endtask

  // Expected frame: fixed header fields with hand-computed length/checksum, payload, zero pad.
  task automatic build_exp(input int tuser_len, input int npay, input logic [15:0] csum);
    logic [335:0] hdr;
    logic [15:0] ipl, udpl;
    ipl  = 16'(tuser_len + 28);
    udpl = 16'(tuser_len + 8);
    hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h4500, ipl,
           16'h0000, 16'h4000, 16'h4011, csum, 32'hC0A8_010A, 32'hC0A8_0164,
           16'd5000, 16'd5001, udpl, 16'h0000};
    exp_q.delete();
    for (int i = 0; i < 42; i++) exp_q.push_back(hdr[335 - 8*i -: 8]);
    for (int i = 0; i < npay; i++) exp_q.push_back(pay_mem[i]);
`ifdef UDP_FRAMER_PAD_EN
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic send_pkt(input int n, input int tuser, input int last_at);
    int waited;
    bit hs;
    hs_count = 0;
    for (int i = 0; i < n; i++) begin
      s_axis_data  = pay_mem[i];
      s_axis_valid = 1'b1;
      s_axis_last  = (i == last_at);
      s_axis_tuser = 12'(tuser);
      waited = 0;
      hs = 1'b0;
      while (!hs && waited < 400) begin
        @(negedge clk);
        hs = s_axis_ready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (!hs) begin
        chk("send_timeout", 1, 0);
        break;
      end
      hs_count++;
    end
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int i;
    for (i = 0; i < 600 && last_cnt == 0; i++) @(posedge clk);
    if (last_cnt == 0) chk({tag, "_frame_timeout"}, 1, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    int mism;
    mism = 0;
    chk({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) mism++;
    chk({tag, "_bytes_mismatched"}, mism, 0);
    chk({tag, "_last_idx"}, last_idx, exp_q.size() - 1);
    chk({tag, "_last_cnt"}, last_cnt, 1);
  endtask

  initial begin
    string msg;
    int pad_len4;
    msg = "SWITCHES CHANGED! NEW VALUE: 0x1234\r\n";
    for (int i = 0; i < 2000; i++) pay_mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 37; i++) pay_mem[i] = msg[i];

    reset = 1'b1;
    s_axis_data = 8'h00;
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    s_axis_tuser = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_axis_valid, 0);
    chk("rst_m_last", m_axis_last, 0);
    chk("rst_m_data", m_axis_data, 0);
    chk("rst_s_ready", s_axis_ready, 0);
    chk("rst_err_len", err_len, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // L=37, ready held high
    clear_mon();
    send_pkt(37, 37, 36);
    wait_frame("l37");
    build_exp(37, 37, 16'hB6ED);
    check_frame("l37");
    chk("l37_ip_len_hi", cap_q[OFF_IP_LEN], 8'h00);
    chk("l37_ip_len_lo", cap_q[OFF_IP_LEN+1], 8'h41);
    chk("l37_csum_hi", cap_q[OFF_IP_CSUM], 8'hB6);
    chk("l37_csum_lo", cap_q[OFF_IP_CSUM+1], 8'hED);
    chk("l37_udp_len_hi", cap_q[OFF_UDP_LEN], 8'h00);
    chk("l37_udp_len_lo", cap_q[OFF_UDP_LEN+1], 8'h2D);
    chk("l37_err", err_cnt, 0);

    // L=4: minimum-frame padding boundary
    clear_mon();
    send_pkt(4, 4, 3);
    wait_frame("l4");
    build_exp(4, 4, 16'hB70E);
`ifdef UDP_FRAMER_PAD_EN
    pad_len4 = 60;
`else
    pad_len4 = 46;
`endif
    chk("l4_total_len", cap_q.size(), pad_len4);
    check_frame("l4");

    // L=37 with ready toggling every cycle
    clear_mon();
    toggle_ready = 1'b1;
    send_pkt(37, 37, 36);
    wait_frame("l37_tog");
    toggle_ready = 1'b0;
    @(posedge clk);
    #1;
    build_exp(37, 37, 16'hB6ED);
    check_frame("l37_tog");

    // tuser=37 but last arrives on payload byte 20
    clear_mon();
    send_pkt(21, 37, 20);
    wait_frame("short");
    build_exp(37, 21, 16'hB6ED);
    check_frame("short");
    chk("short_err_pulses", err_cnt, 1);

    clear_mon();
    send_pkt(37, 37, 36);
    wait_frame("after_short");
    build_exp(37, 37, 16'hB6ED);
    check_frame("after_short");
    chk("after_short_err", err_cnt, 0);

    // Oversize length: everything drained, nothing emitted
    clear_mon();
    send_pkt(2000, 2000, 1999);
    repeat (4) @(posedge clk);
    #1;
    chk("big_consumed", hs_count, 2000);
    chk("big_err_pulses", err_cnt, 1);
    chk("big_valid_seen", valid_seen, 0);
    chk("big_idle_ready", s_axis_ready, 0);

    // Asynchronous reset part way through the header
    clear_mon();
    s_axis_data  = pay_mem[0];
    s_axis_tuser = 12'd37;
    s_axis_last  = 1'b0;
    s_axis_valid = 1'b1;
    for (int i = 0; i < 300 && cap_q.size() < 10; i++) @(negedge clk);
    chk("mid_hdr_reached", (cap_q.size() >= 10) ? 1 : 0, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", m_axis_valid, 0);
    chk("async_rst_ready", s_axis_ready, 0);
    s_axis_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    send_pkt(37, 37, 36);
    wait_frame("post_rst");
    build_exp(37, 37, 16'hB6ED);
    check_frame("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
